// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register with load-use stall, flush and hold
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_id,
  input  logic [31:0] PC_id,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [11:0] csr_id,
  input  logic [31:0] operand1_id,
  input  logic [31:0] operand2_id,
  input  logic [31:0] csr_value_id,
  input  logic [4:0]  rd_id,
  input  logic        write_reg_id,
  input  logic        csr_write_id,
  input  logic        is_load_id,
  input  logic        flush_ex,
  input  logic        hold_ex,
  output logic        valid_stage1,
  output logic [31:0] PC_stage1,
  output logic [4:0]  rs1_stage1,
  output logic [4:0]  rs2_stage1,
  output logic [11:0] csr_stage1,
  output logic [31:0] operand1_stage1,
  output logic [31:0] operand2_stage1,
  output logic [31:0] csr_result_stage1,
  output logic [4:0]  destination_reg_stage1,
  output logic        write_reg_stage1,
  output logic        csr_write_reg_stage1,
  output logic        is_load_stage1,
  output logic        stall_id
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {RUN, STALL, HOLD} state_t;

  state_t     state;
  state_t     ret_state;
  state_t     eff_state;
  logic [1:0] cnt;
  logic       lu;
  logic       do_bubble;
  logic       do_capture;

  // While held, decisions are made as if in the state the hold interrupted.
  assign eff_state = (state == HOLD) ? ret_state : state;

  assign lu = valid_id & is_load_stage1 & write_reg_stage1 &
              ((destination_reg_stage1 == rs1_id) | (destination_reg_stage1 == rs2_id));

  always_comb begin
    stall_id = 1'b0;
    if (flush_ex)
      stall_id = 1'b0;
    else if (hold_ex)
      stall_id = 1'b1;
    else if (eff_state == STALL)
      stall_id = 1'b1;
    else
      stall_id = lu;
  end

  assign do_bubble  = flush_ex | (~hold_ex & ((eff_state == STALL) | lu));
  assign do_capture = ~flush_ex & ~hold_ex & (eff_state == RUN) & ~lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= 2'd0;
    end else if (flush_ex) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= 2'd0;
    end else if (hold_ex) begin
      state     <= HOLD;
      ret_state <= eff_state;
    end else if (eff_state == STALL) begin
      cnt   <= cnt - 2'd1;
      state <= (cnt == 2'd1) ? RUN : STALL;
    end else if (lu) begin
      cnt   <= 2'(LOAD_USE_BUBBLES - 1);
      state <= (LOAD_USE_BUBBLES > 1) ? STALL : RUN;
    end else begin
      state <= RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || (rst_n && do_bubble)) begin
      valid_stage1           <= 1'b0;
      PC_stage1              <= 32'd0;
      rs1_stage1             <= 5'd0;
      rs2_stage1             <= 5'd0;
      csr_stage1             <= 12'd0;
      operand1_stage1        <= 32'd0;
      operand2_stage1        <= 32'd0;
      csr_result_stage1      <= 32'd0;
      destination_reg_stage1 <= 5'd0;
      write_reg_stage1       <= 1'b0;
      csr_write_reg_stage1   <= 1'b0;
      is_load_stage1         <= 1'b0;
    end else if (do_capture) begin
      valid_stage1           <= valid_id;
      PC_stage1              <= PC_id;
      rs1_stage1             <= rs1_id;
      rs2_stage1             <= rs2_id;
      csr_stage1             <= csr_id;
      operand1_stage1        <= operand1_id;
      operand2_stage1        <= operand2_id;
      csr_result_stage1      <= csr_value_id;
      destination_reg_stage1 <= rd_id;
      // x0 is never marked written so forwarding cannot match on it.
      write_reg_stage1       <= write_reg_id & valid_id & (rd_id != 5'd0);
      csr_write_reg_stage1   <= csr_write_id & valid_id;
      is_load_stage1         <= is_load_id & valid_id;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (stall_id)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_ex)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - table-driven bench for id_ex_stage with LOAD_USE_BUBBLES=2
// Perf counter checks are compiled in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

  localparam logic [1:0] CAP = 2'd0, BUB = 2'd1, KEEP = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_id = 1'b0;
  logic [31:0] PC_id = '0;
  logic [4:0]  rs1_id = '0, rs2_id = '0, rd_id = '0;
  logic [11:0] csr_id = '0;
  logic [31:0] operand1_id = '0, operand2_id = '0, csr_value_id = '0;
  logic        write_reg_id = 1'b0, csr_write_id = 1'b0, is_load_id = 1'b0;
  logic        flush_ex = 1'b0, hold_ex = 1'b0;

  logic        valid_stage1;
  logic [31:0] PC_stage1;
  logic [4:0]  rs1_stage1, rs2_stage1, destination_reg_stage1;
  logic [11:0] csr_stage1;
  logic [31:0] operand1_stage1, operand2_stage1, csr_result_stage1;
  logic        write_reg_stage1, csr_write_reg_stage1, is_load_stage1, stall_id;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  id_ex_stage #(.LOAD_USE_BUBBLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .PC_id(PC_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .csr_id(csr_id),
    .operand1_id(operand1_id), .operand2_id(operand2_id), .csr_value_id(csr_value_id),
    .rd_id(rd_id), .write_reg_id(write_reg_id), .csr_write_id(csr_write_id),
    .is_load_id(is_load_id), .flush_ex(flush_ex), .hold_ex(hold_ex),
    .valid_stage1(valid_stage1), .PC_stage1(PC_stage1),
    .rs1_stage1(rs1_stage1), .rs2_stage1(rs2_stage1), .csr_stage1(csr_stage1),
    .operand1_stage1(operand1_stage1), .operand2_stage1(operand2_stage1),
    .csr_result_stage1(csr_result_stage1), .destination_reg_stage1(destination_reg_stage1),
    .write_reg_stage1(write_reg_stage1), .csr_write_reg_stage1(csr_write_reg_stage1),
    .is_load_stage1(is_load_stage1), .stall_id(stall_id)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, ld, cw, fl, hd;
    logic [31:0] op1;
    logic        e_st, e_v;
    logic [31:0] e_pc;
    logic        e_wr, e_ld, e_cw;
    logic [4:0]  e_rd;
    logic [31:0] e_op1;
    logic [1:0]  act;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  logic [4:0]  m_rs1, m_rs2;
  logic [11:0] m_csr;
  logic [31:0] m_op2, m_csrv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                     input logic wr, ld, cw, fl, hd, input logic [31:0] op1,
                     input logic e_st, e_v, input logic [31:0] e_pc,
                     input logic e_wr, e_ld, e_cw, input logic [4:0] e_rd,
                     input logic [31:0] e_op1, input logic [1:0] act);
    vec_t r;
    r.v = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.wr = wr; r.ld = ld; r.cw = cw; r.fl = fl; r.hd = hd; r.op1 = op1;
    r.e_st = e_st; r.e_v = e_v; r.e_pc = e_pc; r.e_wr = e_wr; r.e_ld = e_ld;
    r.e_cw = e_cw; r.e_rd = e_rd; r.e_op1 = e_op1; r.act = act;
    vecs.push_back(r);
  endtask

  task automatic drive(input vec_t r);
    valid_id = r.v; PC_id = r.pc; rs1_id = r.rs1; rs2_id = r.rs2; rd_id = r.rd;
    write_reg_id = r.wr; is_load_id = r.ld; csr_write_id = r.cw;
    flush_ex = r.fl; hold_ex = r.hd; csr_id = r.pc[11:0];
    operand1_id = r.op1; operand2_id = r.op1 ^ 32'h5A5A_0000; csr_value_id = r.op1 + 32'd7;
  endtask

  initial begin
    int exp_stalls;
    int exp_flushes;
    // Normal capture and x0 qualification
    add(1,'h100,3,4,5, 1,0,1,0,0,'hAAAA, 0,1,'h100,1,0,1,5,'hAAAA,CAP);
    add(1,'h104,1,2,0, 1,0,0,0,0,'h1111, 0,1,'h104,0,0,0,0,'h1111,CAP);
    add(0,'h108,1,2,6, 1,1,1,0,0,'h2222, 0,0,'h108,0,0,0,6,'h2222,CAP);
    // Load-use on rs1: two bubbles then the add
    add(1,'h200,2,0,7, 1,1,0,0,0,'h3333, 0,1,'h200,1,1,0,7,'h3333,CAP);
    add(1,'h204,7,1,8, 1,0,0,0,0,'h1234, 1,0,0,0,0,0,0,0,BUB);
    add(1,'h204,7,1,8, 1,0,0,0,0,'h1234, 1,0,0,0,0,0,0,0,BUB);
    add(1,'h204,7,1,8, 1,0,0,0,0,'h1234, 0,1,'h204,1,0,0,8,'h1234,CAP);
    // Load-use on rs2
    add(1,'h210,0,0,7, 1,1,0,0,0,'h4444, 0,1,'h210,1,1,0,7,'h4444,CAP);
    add(1,'h214,1,7,9, 1,0,0,0,0,'h5555, 1,0,0,0,0,0,0,0,BUB);
    add(1,'h214,1,7,9, 1,0,0,0,0,'h5555, 1,0,0,0,0,0,0,0,BUB);
    add(1,'h214,1,7,9, 1,0,0,0,0,'h5555, 0,1,'h214,1,0,0,9,'h5555,CAP);
    // No register match, and a load to x0 never stalls
    add(1,'h220,0,0,7, 1,1,0,0,0,'h6666, 0,1,'h220,1,1,0,7,'h6666,CAP);
    add(1,'h224,6,1,10,1,0,0,0,0,'h7777, 0,1,'h224,1,0,0,10,'h7777,CAP);
    add(1,'h230,0,0,0, 1,1,0,0,0,'h8888, 0,1,'h230,0,1,0,0,'h8888,CAP);
    add(1,'h234,0,0,3, 1,0,0,0,0,'h9999, 0,1,'h234,1,0,0,3,'h9999,CAP);
    // Flush during a load-use stall returns to RUN
    add(1,'h240,0,0,7, 1,1,0,0,0,'hABCD, 0,1,'h240,1,1,0,7,'hABCD,CAP);
    add(1,'h244,7,2,12,1,0,0,0,0,'hBEEF, 1,0,0,0,0,0,0,0,BUB);
    add(1,'h244,7,2,12,1,0,0,1,0,'hBEEF, 0,0,0,0,0,0,0,0,BUB);
    add(1,'h244,7,2,12,1,0,0,0,0,'hBEEF, 0,1,'h244,1,0,0,12,'hBEEF,CAP);
    // Three-cycle hold, then hold together with flush
    add(1,'h300,1,2,11,1,0,1,0,0,'hC0DE, 0,1,'h300,1,0,1,11,'hC0DE,CAP);
    for (int k = 0; k < 3; k++)
      add(1,'h304,3,4,13,1,0,0,0,1,'hD00D, 1,1,'h300,1,0,1,11,'hC0DE,KEEP);
    add(1,'h304,3,4,13,1,0,0,0,0,'hD00D, 0,1,'h304,1,0,0,13,'hD00D,CAP);
    add(1,'h308,1,1,14,1,0,0,1,1,'hE0E0, 0,0,0,0,0,0,0,0,BUB);
    // Hold in the middle of a stall resumes the remaining bubble
    add(1,'h310,0,0,7, 1,1,0,0,0,'hF00F, 0,1,'h310,1,1,0,7,'hF00F,CAP);
    add(1,'h314,7,0,15,1,0,0,0,0,'h0F0F, 1,0,0,0,0,0,0,0,BUB);
    add(1,'h314,7,0,15,1,0,0,0,1,'h0F0F, 1,0,0,0,0,0,0,0,KEEP);
    add(1,'h314,7,0,15,1,0,0,0,0,'h0F0F, 1,0,0,0,0,0,0,0,BUB);
    add(1,'h314,7,0,15,1,0,0,0,0,'h0F0F, 0,1,'h314,1,0,0,15,'h0F0F,CAP);

    m_rs1 = '0; m_rs2 = '0; m_csr = '0; m_op2 = '0; m_csrv = '0;
    exp_stalls = 0; exp_flushes = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, valid_stage1}, 32'd0);
    chk("reset_pc", PC_stage1, 32'd0);
    chk("reset_stall", {31'd0, stall_id}, 32'd0);
    chk("reset_wr", {31'd0, write_reg_stage1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t r;
      string t;
      r = vecs[i];
      @(negedge clk);
      drive(r);
      #1;
      t = $sformatf("v%0d_", i);
      chk({t, "stall"}, {31'd0, stall_id}, {31'd0, r.e_st});
      exp_stalls += int'(r.e_st);
      exp_flushes += int'(r.fl);
      @(posedge clk);
      #1;
      if (r.act == CAP) begin
        m_rs1 = r.rs1; m_rs2 = r.rs2; m_csr = r.pc[11:0];
        m_op2 = r.op1 ^ 32'h5A5A_0000; m_csrv = r.op1 + 32'd7;
      end else if (r.act == BUB) begin
        m_rs1 = '0; m_rs2 = '0; m_csr = '0; m_op2 = '0; m_csrv = '0;
      end
      chk({t, "valid"}, {31'd0, valid_stage1}, {31'd0, r.e_v});
      chk({t, "pc"}, PC_stage1, r.e_pc);
      chk({t, "wr"}, {31'd0, write_reg_stage1}, {31'd0, r.e_wr});
      chk({t, "ld"}, {31'd0, is_load_stage1}, {31'd0, r.e_ld});
      chk({t, "csrw"}, {31'd0, csr_write_reg_stage1}, {31'd0, r.e_cw});
      chk({t, "rd"}, {27'd0, destination_reg_stage1}, {27'd0, r.e_rd});
      chk({t, "op1"}, operand1_stage1, r.e_op1);
      chk({t, "rs1"}, {27'd0, rs1_stage1}, {27'd0, m_rs1});
      chk({t, "rs2"}, {27'd0, rs2_stage1}, {27'd0, m_rs2});
      chk({t, "csr"}, {20'd0, csr_stage1}, {20'd0, m_csr});
      chk({t, "op2"}, operand2_stage1, m_op2);
      chk({t, "csrv"}, csr_result_stage1, m_csrv);
    end

`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall_cycles", stall_cycles, 32'(exp_stalls));
    chk("perf_flush_count", flush_count, 32'(exp_flushes));
`endif

    // Asynchronous reset while stalling with one bubble left
    @(negedge clk);
    valid_id = 1; PC_id = 32'h400; rs1_id = 0; rs2_id = 0; rd_id = 7;
    write_reg_id = 1; is_load_id = 1; flush_ex = 0; hold_ex = 0;
    @(negedge clk);
    PC_id = 32'h404; rs1_id = 7; rd_id = 16; is_load_id = 0;
    #1;
    chk("rst_pre_stall", {31'd0, stall_id}, 32'd1);
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stall_id}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_stall", {31'd0, stall_id}, 32'd0);
    chk("rst_async_valid", {31'd0, valid_stage1}, 32'd0);
    chk("rst_async_pc", PC_stage1, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("rst_async_stall_cycles", stall_cycles, 32'd0);
    chk("rst_async_flush_count", flush_count, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_resume_pc", PC_stage1, 32'h404);
    chk("rst_resume_valid", {31'd0, valid_stage1}, 32'd1);
    chk("rst_resume_stall", {31'd0, stall_id}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
